// File: rtl/samp_pack.sv
// samp_pack: arm/trig-gated packer of 64-bit beat pairs into batches replayed as one contiguous burst (SAMP_PACK_SEQ_EN tags each burst's first word with a batch sequence byte)
module samp_pack #(
  parameter int WIDTH_IN    = 64,
  parameter int WIDTH_WR    = 128,
  parameter int BATCH_WORDS = 16,
  parameter int HOLDOFF     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                samp_valid,
  input  logic [WIDTH_IN-1:0] samp_in,
  input  logic                arm,
  input  logic                trig,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic [WIDTH_WR-1:0] samp_out
);
  localparam int AW = $clog2(BATCH_WORDS);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(HOLDOFF + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] FILL  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] wcnt, rcnt;
  logic [GW-1:0] gcnt;
  logic half;
  logic [WIDTH_IN-1:0] lo;
  logic [WIDTH_WR-1:0] mem [BATCH_WORDS];
  logic [WIDTH_WR-1:0] rd, rd_word;
  logic capture, we;
  assign busy = state != IDLE;
  assign capture = samp_valid && ((state == ARM && trig) || state == FILL);
  assign we = capture && half;
  assign rd = mem[rcnt[AW-1:0]];
  always_ff @(posedge clk)
    if (we) mem[wcnt[AW-1:0]] <= {samp_in, lo};
`ifdef SAMP_PACK_SEQ_EN
  logic [7:0] seq;
  always_ff @(posedge clk)
    seq <= rst ? 8'd0 : seq + 8'(state == DRAIN && rcnt == CW'(BATCH_WORDS - 1));
  always_comb rd_word = rcnt == '0 ? {seq, rd[WIDTH_WR-9:0]} : rd;
`else
  always_comb rd_word = rd;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      gcnt     <= '0;
      half     <= 1'b0;
      lo       <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
      samp_out <= '0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      if (capture && !half) lo <= samp_in;
      if (capture) half <= !half;
      if (we) wcnt <= wcnt + 1'b1;
      case (state)
        IDLE: if (arm) state <= ARM;
        ARM: if (trig) begin
          state <= FILL;
          wcnt  <= '0;
        end
        FILL: if (we && wcnt == CW'(BATCH_WORDS - 1)) begin
          state <= DRAIN;
          rcnt  <= '0;
        end
        DRAIN: if (rcnt != CW'(BATCH_WORDS)) begin
          valid    <= 1'b1;
          samp_out <= rd_word;
          done     <= rcnt == CW'(BATCH_WORDS - 1);
          rcnt     <= rcnt + 1'b1;
        end else begin
          state <= GAP;
          gcnt  <= '0;
        end
        GAP: if (gcnt == GW'(HOLDOFF - 1)) state <= IDLE; else gcnt <= gcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
